// File: rtl/anffl_tex_block_fetch.sv
// Texture block fetch stage: turns one texel lookup into a compressed ETC2
// block address, reads the block over a 32-bit memory port, assembles it
// into the decoder's 128-bit layout and keeps a single-entry block cache so
// repeated lookups into the same block skip memory entirely.
module anffl_tex_block_fetch #(
    parameter int ADDR_W   = 32,
    parameter int COORD_W  = 12,
    parameter int STRIDE_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [COORD_W-1:0]  req_u,
    input  logic [COORD_W-1:0]  req_v,
    input  logic [ADDR_W-1:0]   req_base,
    input  logic [STRIDE_W-1:0] req_stride,
    input  logic [4:0]          req_format,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rsp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic [4:0]          out_format,
    output logic [1:0]          out_uTexel,
    output logic [1:0]          out_vTexel
);

    localparam int BLK_W = COORD_W - 2;
    localparam int IDX_W = BLK_W + STRIDE_W + 1;
    localparam int OFF_W = IDX_W + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_WAIT,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [4:0]        format;
        logic [BLK_W-1:0]  bx;
        logic [BLK_W-1:0]  by;
    } tag_t;

    state_t            state_q, next_state;
    tag_t              req_tag_q, cache_tag;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        ut_q, vt_q;
    logic [1:0]        beat_q;
    logic [127:0]      asm_q, cache_data, fill_data;
    logic              cache_valid;

    logic [BLK_W-1:0]  req_bx, req_by;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [1:0]        last_beat, slot;
    logic              accept, hit, take, is_last, fill, miss;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_bx    = req_u[COORD_W-1:2];
    assign req_by    = req_v[COORD_W-1:2];

    assign last_beat = (req_tag_q.format == 5'd1) ? 2'd3 : 2'd1;
    assign is_last   = (beat_q == last_beat);
    assign slot      = last_beat - beat_q;
    assign hit       = cache_valid && (cache_tag == req_tag_q);
    assign miss      = (state_q == S_CHECK) && !hit;
    assign take      = (state_q == S_WAIT) && mem_rsp_valid;
    assign fill      = take && is_last;

    // Block byte offset at full product width; adding into ADDR_W bits wraps.
    always_comb begin
        req_idx = IDX_W'(req_by) * IDX_W'(req_stride) + IDX_W'(req_bx);
        req_off = (req_format == 5'd1) ? {req_idx, 4'b0000} : {1'b0, req_idx, 3'b000};
    end

    // Merge the arriving little-endian word into its big-endian slot; the
    // first beat lands highest so block byte 0 ends up in the top byte.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fill_data = asm_q;
        fill_data[{slot, 5'b00000} +: 32] = {mem_rsp_data[7:0], mem_rsp_data[15:8],
                                             mem_rsp_data[23:16], mem_rsp_data[31:24]};
    end

    // Next-state decode.
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)        next_state = S_CHECK;
            S_CHECK: next_state = hit ? S_OUT : S_FETCH;
            S_FETCH: if (mem_req_ready) next_state = S_WAIT;
            S_WAIT:  if (mem_rsp_valid) next_state = is_last ? S_OUT : S_FETCH;
            S_OUT:   if (out_ready)     next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= next_state;
    end

    // Registered outputs and beat counter, all tracking next_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            beat_q        <= 2'd0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_format    <= 5'd0;
            out_uTexel    <= 2'd0;
            out_vTexel    <= 2'd0;
        end else begin
            mem_req_valid <= (next_state == S_FETCH);
            out_valid     <= (next_state == S_OUT);
            if (miss) begin
                beat_q   <= 2'd0;
                mem_addr <= addr_q;
            end else if (take && !is_last) begin
                beat_q   <= beat_q + 2'd1;
                mem_addr <= addr_q + ADDR_W'({beat_q + 2'd1, 2'b00});
            end
            if (next_state == S_OUT && state_q != S_OUT) begin
                out_data   <= (state_q == S_CHECK) ? cache_data : fill_data;
                out_format <= req_tag_q.format;
                out_uTexel <= ut_q;
                out_vTexel <= vt_q;
            end
        end
    end

    // Cache valid: a last-beat fill beats a coincident invalidate.
    always_ff @(posedge clk) begin
        if (rst)       cache_valid <= 1'b0;
        else if (fill) cache_valid <= 1'b1;
        else if (inv)  cache_valid <= 1'b0;
    end

    // Request latch, assembly register and cache storage.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; cache_valid and the FSM guard every use of it.
        if (accept) begin
            req_tag_q <= '{base: req_base, format: req_format, bx: req_bx, by: req_by};
            addr_q    <= req_base + ADDR_W'(req_off);
            ut_q      <= req_u[1:0];
            vt_q      <= req_v[1:0];
        end
        if (miss)      asm_q <= '0;
        else if (take) asm_q <= fill_data;
        if (fill) begin
            cache_tag  <= req_tag_q;
            cache_data <= fill_data;
        end
    end

endmodule

// File: tb/tb_anffl_tex_block_fetch.sv
// Self-checking bench for anffl_tex_block_fetch: scoreboard of expected
// blocks and memory addresses, zero-wait memory responder with optional
// request stall, and latency / hit / invalidate / reset / wrap scenarios.
module tb_anffl_tex_block_fetch;

    logic         clk, rst, inv;
    logic         req_valid, req_ready;
    logic [11:0]  req_u, req_v;
    logic [31:0]  req_base;
    logic [9:0]   req_stride;
    logic [4:0]   req_format;
    logic         mem_req_valid, mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_format;
    logic [1:0]   out_uTexel, out_vTexel;

    anffl_tex_block_fetch dut (
        .clk(clk), .rst(rst), .inv(inv),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_u(req_u), .req_v(req_v), .req_base(req_base),
        .req_stride(req_stride), .req_format(req_format),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_format(out_format), .out_uTexel(out_uTexel), .out_vTexel(out_vTexel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   fmt;
        logic [1:0]   ut;
        logic [1:0]   vt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr[$];
    logic [31:0] mem_pre[logic [31:0]];
    int          mem_hs     = 0;
    int          stall_left = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_pre.exists(a)) return mem_pre[a];
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] blk_addr(input logic [31:0] base, input logic [9:0] stride,
                                             input logic [11:0] u, input logic [11:0] v,
                                             input logic [4:0] fmt);
        longint unsigned bx, by, nb, full;
        bx   = longint'(u >> 2);
        by   = longint'(v >> 2);
        nb   = (fmt == 5'd1) ? 16 : 8;
        full = longint'(base) + (by * longint'(stride) + bx) * nb;
        return 32'(full);
    endfunction

    function automatic logic [127:0] blk_data(input logic [31:0] a, input logic [4:0] fmt);
        logic [127:0] d;
        logic [31:0]  w;
        int           nb;
        d  = '0;
        nb = (fmt == 5'd1) ? 16 : 8;
        for (int i = 0; i < nb; i++) begin
            w = mem_word(a + 32'(i & ~3));
            d[8*(nb-i)-1 -: 8] = w[8*(i%4) +: 8];
        end
        return d;
    endfunction

    // Zero-wait memory: answer each accepted read in the following cycle.
    initial begin
        logic [31:0] a;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_valid) begin
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                    if (exp_addr.size() > 0) check("mem_addr_stall", mem_addr, exp_addr[0]);
                    else                     check("mem_unexpected_req", mem_req_valid, 0);
                end else begin
                    mem_req_ready = 1'b1;
                    mem_hs++;
                    if (exp_addr.size() > 0) check("mem_addr", mem_addr, exp_addr.pop_front());
                    else                     check("mem_unexpected_req", mem_req_valid, 0);
                    a = mem_addr;
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(a);
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = '0;
                end
            end
        end
    end

    task automatic send_req(input string name, input logic [31:0] base, input logic [9:0] stride,
                            input logic [11:0] u, input logic [11:0] v, input logic [4:0] fmt,
                            output int acc);
        @(negedge clk);
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        check({name, "_req_ready"}, req_ready, 1);
        req_valid  = 1'b1;
        req_base   = base;
        req_stride = stride;
        req_u      = u;
        req_v      = v;
        req_format = fmt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic do_lookup(input string name, input logic [31:0] base, input logic [9:0] stride,
                             input logic [11:0] u, input logic [11:0] v, input logic [4:0] fmt,
                             input logic [127:0] exp_data, input bit exp_hit,
                             input int mem_stall, input int out_stall, input bit inv_last);
        int   beats, hs0, acc, lat;
        bit   seen;
        exp_t e;
        logic [31:0] a;
        beats = (fmt == 5'd1) ? 4 : 2;
        a     = blk_addr(base, stride, u, v, fmt);
        if (!exp_hit)
            for (int k = 0; k < beats; k++) exp_addr.push_back(a + 32'(4 * k));
        sb.push_back('{exp_data, fmt, u[1:0], v[1:0]});
        stall_left = mem_stall;
        hs0        = mem_hs;
        send_req(name, base, stride, u, v, fmt, acc);
        if (inv_last) begin
            // Cycle accept+5 is the WAIT of the last RGB beat.
            repeat (4) @(posedge clk);
            #1 inv = 1'b1;
            @(posedge clk);
            #1 inv = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_out_valid_seen"}, seen, 1);
        if (!seen) begin
            sb.delete();
            exp_addr.delete();
            return;
        end
        lat = cyc - acc + 1;
        check({name, "_latency"}, lat, (exp_hit ? 2 : 2 + 2 * beats) + mem_stall);
        check({name, "_mem_beats"}, mem_hs - hs0, exp_hit ? 0 : beats);
        for (int n = 0; n < out_stall; n++) begin
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_data"}, out_data, sb[0].data);
            @(negedge clk);
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        check({name, "_data"}, out_data, e.data);
        check({name, "_format"}, out_format, e.fmt);
        check({name, "_utexel"}, out_uTexel, e.ut);
        check({name, "_vtexel"}, out_vTexel, e.vt);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ready_after_out"}, req_ready, 1);
        check({name, "_valid_dropped"}, out_valid, 0);
    endtask

    // Bound the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst = 1'b1; inv = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_u = '0; req_v = '0; req_base = '0; req_stride = '0; req_format = '0;
        mem_pre[32'h0000_1048] = 32'h4433_2211;
        mem_pre[32'h0000_104C] = 32'h8877_6655;
        mem_pre[32'h0000_1090] = 32'h0302_0100;
        mem_pre[32'h0000_1094] = 32'h0706_0504;
        mem_pre[32'h0000_1098] = 32'h0B0A_0908;
        mem_pre[32'h0000_109C] = 32'h0F0E_0D0C;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Misses and hits for RGB and RGBA at the same coordinates.
        do_lookup("rgb_miss", 32'h1000, 10'd7, 12'd9, 12'd6, 5'd0,
                  128'h1122_3344_5566_7788, 1'b0, 0, 0, 1'b0);
        do_lookup("rgb_hit", 32'h1000, 10'd7, 12'd10, 12'd7, 5'd0,
                  128'h1122_3344_5566_7788, 1'b1, 0, 0, 1'b0);
        do_lookup("rgba_miss", 32'h1000, 10'd7, 12'd9, 12'd6, 5'd1,
                  128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 1'b0, 0, 0, 1'b0);
        do_lookup("rgba_hit", 32'h1000, 10'd7, 12'd10, 12'd7, 5'd1,
                  128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 1'b1, 0, 0, 1'b0);

        // Idle invalidate forces a refetch.
        @(negedge clk);
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        do_lookup("inv_refetch", 32'h1000, 10'd7, 12'd9, 12'd6, 5'd1,
                  128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, 1'b0, 0, 0, 1'b0);

        // Invalidate coinciding with the last-beat fill: the fill wins.
        do_lookup("inv_last_fill", 32'h1000, 10'd7, 12'd9, 12'd6, 5'd0,
                  128'h1122_3344_5566_7788, 1'b0, 0, 0, 1'b1);
        do_lookup("inv_last_hit", 32'h1000, 10'd7, 12'd10, 12'd7, 5'd0,
                  128'h1122_3344_5566_7788, 1'b1, 0, 0, 1'b0);

        // Memory and decoder backpressure.
        do_lookup("backpressure", 32'h1000, 10'd7, 12'd20, 12'd6, 5'd0,
                  blk_data(blk_addr(32'h1000, 10'd7, 12'd20, 12'd6, 5'd0), 5'd0),
                  1'b0, 5, 4, 1'b0);

        // Reset during WAIT of beat 1 of an RGBA fetch.
        for (int k = 0; k < 4; k++) exp_addr.push_back(32'h2000 + 32'(4 * k));
        send_req("rst_mid", 32'h2000, 10'd7, 12'd0, 12'd0, 5'd1, acc);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req_ready", req_ready, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_out_format", out_format, 0);
        check("rst_mid_texels", {out_uTexel, out_vTexel}, 0);
        check("rst_mid_mem_req_valid", mem_req_valid, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_idle", req_ready, 1);
        exp_addr.delete();
        do_lookup("post_rst_miss", 32'h1000, 10'd7, 12'd20, 12'd6, 5'd0,
                  blk_data(blk_addr(32'h1000, 10'd7, 12'd20, 12'd6, 5'd0), 5'd0),
                  1'b0, 0, 0, 1'b0);

        // Address wrap-around: base + 8 wraps to zero.
        do_lookup("wrap", 32'hFFFF_FFF8, 10'd3, 12'd4, 12'd0, 5'd0,
                  blk_data(32'h0000_0000, 5'd0), 1'b0, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("leftover_mem_addrs", exp_addr.size(), 0);
        check("leftover_blocks", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
